// File: rtl/rv_pkg.sv
// rv_pkg: shared rename-stage parameters, tag types and the decode control bundle
package rv_pkg;
    localparam int NUM_AREGS = 32;
    localparam int NUM_PREGS = 64;
    localparam int PREG_W = $clog2(NUM_PREGS);
    localparam int AREG_W = $clog2(NUM_AREGS);
    localparam int FL_N = NUM_PREGS - NUM_AREGS;
    localparam int FL_IDX_W = $clog2(FL_N);
    localparam int CNT_W = PREG_W + 1;
    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [FL_IDX_W-1:0] fl_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [31:0] imm;
        logic [3:0]  alu_control;
        logic        alu_src;
        logic        load_store;
        logic        regwrite;
        logic        bms;
        logic [2:0]  spare;
    } ctrl_bundle_t;
    localparam int CTRL_W = $bits(ctrl_bundle_t);
    function automatic fl_idx_t fl_next(input fl_idx_t i);
        return (i == fl_idx_t'(FL_N - 1)) ? '0 : i + fl_idx_t'(1);
    endfunction
endpackage

// File: rtl/rename_free_list.sv
// rename_free_list: circular FIFO of free physical tags, preloaded with the non-architectural tags
module rename_free_list
    import rv_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  pop,
    input  logic  push,
    input  preg_t push_tag,
    output preg_t head_tag,
    output cnt_t  count
);
    preg_t   mem [FL_N];
    fl_idx_t head;
    fl_idx_t tail;
    logic    do_push;
    assign do_push = push && (count != cnt_t'(FL_N));
    assign head_tag = mem[head];
    // pointer, occupancy and storage update; a push into a full list is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            count <= cnt_t'(FL_N);
            for (int i = 0; i < FL_N; i++) mem[i] <= preg_t'(NUM_AREGS + i);
        end else begin
            if (pop) head <= fl_next(head);
            if (do_push) begin
                mem[tail] <= push_tag;
                tail <= fl_next(tail);
            end
            count <= count + {{PREG_W{1'b0}}, do_push} - {{PREG_W{1'b0}}, pop};
        end
    end
    a_no_overfill: assert property (@(posedge clk) disable iff (reset) !(push && count == cnt_t'(FL_N)));
endmodule

// File: rtl/rename_stage.sv
// rename_stage: RAT lookup plus free-list allocation, one renamed instruction per cycle to dispatch
module rename_stage
    import rv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AREG_W-1:0] in_rd,
    input  logic [AREG_W-1:0] in_rs1,
    input  logic [AREG_W-1:0] in_rs2,
    input  logic              in_regwrite,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output preg_t             out_prs1,
    output preg_t             out_prs2,
    output preg_t             out_prd,
    output preg_t             out_old_prd,
    output logic              out_alloc,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              free_valid,
    input  preg_t             free_preg,
    output cnt_t              fl_count
);
    preg_t rat [NUM_AREGS];
    preg_t head_tag;
    logic  need_alloc;
    logic  accept;
    logic  pop;
    logic  push;
    assign need_alloc = in_regwrite && (in_rd != '0);
    assign in_ready = (!out_valid || out_ready) && (!need_alloc || fl_count != '0);
    assign accept = in_valid && in_ready;
    assign pop = accept && need_alloc;
    assign push = free_valid && (free_preg != '0);
    rename_free_list u_fl (
        .clk      (clk),
        .reset    (reset),
        .pop      (pop),
        .push     (push),
        .push_tag (free_preg),
        .head_tag (head_tag),
        .count    (fl_count)
    );
    // RAT: identity after reset, rd remapped to the popped tag; x0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_AREGS; i++) rat[i] <= preg_t'(i);
        end else if (pop) begin
            rat[in_rd] <= head_tag;
        end
    end
    // output register: load on accept, hold under backpressure, drop valid once drained
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_prs1 <= '0;
            out_prs2 <= '0;
            out_prd <= '0;
            out_old_prd <= '0;
            out_alloc <= 1'b0;
            out_ctrl <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_prs1 <= rat[in_rs1];
            out_prs2 <= rat[in_rs2];
            out_prd <= need_alloc ? head_tag : '0;
            out_old_prd <= need_alloc ? rat[in_rd] : '0;
            out_alloc <= need_alloc;
            out_ctrl <= in_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
